// File: rtl/gf180mcu_osu_sc_clkdiv_pkg.sv
// Shared definitions for the programmable 12T clock divider.
// Holds the FSM state encoding and the default ratio-code width.
package gf180mcu_osu_sc_clkdiv_pkg;

    localparam int CLKDIV_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_t;

endpackage

// File: rtl/gf180mcu_osu_sc_12t_clkdiv_cnt.sv
// Terminal-count counter for the clock divider: counts 0..lim, then wraps to 0.
// tgl marks the edge where the divided clock changes phase.
module gf180mcu_osu_sc_12T_clkdiv_cnt
    import gf180mcu_osu_sc_clkdiv_pkg::*;
#(
    parameter int WIDTH = CLKDIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    input  logic [WIDTH-1:0] lim,
    output logic             term,
    output logic             tgl
);

    logic [WIDTH-1:0] cnt;

    assign term = (cnt == lim);
    assign tgl  = run && term;

    // lim only changes on a terminal edge, where cnt returns to 0, so cnt never passes lim
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= term ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gf180mcu_osu_sc_12t_clkdiv_prog.sv
// Glitch-free programmable clock divider with stop control, feeding 12T clkbuf cells.
// Y period is 2*(div_act+1); ratio changes and stops land only on full-period boundaries.
module gf180mcu_osu_sc_12t_clkdiv_prog
    import gf180mcu_osu_sc_clkdiv_pkg::*;
#(
    parameter int WIDTH   = CLKDIV_WIDTH,
    parameter int DIV_RST = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV,
    input  logic             LOAD,
    output logic             Y,
    output logic             ACK,
    output logic             BUSY,
    output logic             STOPPED
);

    state_t           state;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_pend;
    logic             pend_v;
    logic             term;
    logic             tgl;
    logic             cnt_clr;
    logic             cnt_run;
    logic             apply;

    assign cnt_run = (state != IDLE);
    assign cnt_clr = (state == IDLE) && EN;
    // end of a low phase is the only safe moment to swap ratios while running
    assign apply   = pend_v && ((state == IDLE) || (term && !Y));
    assign BUSY    = pend_v;

    gf180mcu_osu_sc_12T_clkdiv_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk  (CLK),
        .rst  (RST),
        .clr  (cnt_clr),
        .run  (cnt_run),
        .lim  (div_act),
        .term (term),
        .tgl  (tgl)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            Y       <= 1'b0;
            STOPPED <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (EN) begin
                        state   <= RUN;
                        Y       <= 1'b1;
                        STOPPED <= 1'b0;
                    end else begin
                        Y <= 1'b0;
                    end
                end
                RUN: begin
                    if (tgl) Y <= ~Y;
                    if (!EN) state <= DRAIN;
                end
                DRAIN: begin
                    if (EN) begin
                        state <= RUN;
                        if (tgl) Y <= ~Y;
                    end else if (tgl) begin
                        // finish the high phase, then stop after the matching low phase
                        if (Y) begin
                            Y <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            STOPPED <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    Y       <= 1'b0;
                    STOPPED <= 1'b1;
                end
            endcase
        end
    end

    // a LOAD coinciding with an apply keeps the new code pending behind the applied one
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_act  <= WIDTH'(DIV_RST);
            div_pend <= '0;
            pend_v   <= 1'b0;
            ACK      <= 1'b0;
        end else begin
            ACK <= apply;
            if (apply) div_act <= div_pend;
            if (LOAD) begin
                div_pend <= DIV;
                pend_v   <= 1'b1;
            end else if (apply) begin
                pend_v <= 1'b0;
            end
        end
    end

    specify
        (CLK => Y)       = 0;
        (CLK => ACK)     = 0;
        (CLK => BUSY)    = 0;
        (CLK => STOPPED) = 0;
    endspecify

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_clkdiv_prog.sv
// Directed bench for the programmable clock divider: per-cycle expected outputs
// are queued by the stimulus and compared by an independent negedge monitor.
module tb_gf180mcu_osu_sc_12t_clkdiv_prog;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic [3:0] DIV;
    logic       LOAD;
    logic       Y;
    logic       ACK;
    logic       BUSY;
    logic       STOPPED;

    int         checks = 0;
    int         errors = 0;
    int         vec_n  = 0;
    logic [3:0] exp_q[$];
    int         id_q[$];
    logic [3:0] got_v;
    logic [3:0] exp_v;
    int         id_v;

    gf180mcu_osu_sc_12t_clkdiv_prog #(.WIDTH(4), .DIV_RST(0)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .DIV     (DIV),
        .LOAD    (LOAD),
        .Y       (Y),
        .ACK     (ACK),
        .BUSY    (BUSY),
        .STOPPED (STOPPED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // exp packs {Y, ACK, BUSY, STOPPED} as seen after the edge
    task automatic step(input logic r, input logic e, input logic l,
                        input logic [3:0] d, input logic [3:0] exp);
        RST  = r;
        EN   = e;
        LOAD = l;
        DIV  = d;
        @(posedge CLK);
        exp_q.push_back(exp);
        id_q.push_back(vec_n);
        vec_n++;
        #1;
    endtask

    task automatic phase(input int n, input logic y);
        repeat (n) step(1'b0, 1'b1, 1'b0, 4'd0, {y, 3'b000});
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            id_v  = id_q.pop_front();
            got_v = {Y, ACK, BUSY, STOPPED};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL vec%0d Y/ACK/BUSY/STOPPED: got %b expected %b", id_v, got_v, exp_v);
            end
        end
    end

    initial begin
        RST = 1'b1; EN = 1'b0; LOAD = 1'b0; DIV = 4'd0;
        #1;
        // reset state
        step(1, 0, 0, 4'd0, 4'b0001);
        step(1, 0, 0, 4'd0, 4'b0001);
        step(0, 0, 0, 4'd0, 4'b0001);

        // DIV_RST=0: period 2, then stop from the high phase
        step(0, 1, 0, 4'd0, 4'b1000);
        step(0, 1, 0, 4'd0, 4'b0000);
        step(0, 1, 0, 4'd0, 4'b1000);
        step(0, 0, 0, 4'd0, 4'b0000);
        step(0, 0, 0, 4'd0, 4'b0001);
        step(0, 0, 0, 4'd0, 4'b0001);

        // LOAD 3 in IDLE: pending for one cycle, ACK on the next edge
        step(0, 0, 1, 4'd3, 4'b0011);
        step(0, 0, 0, 4'd0, 4'b0101);
        phase(4, 1'b1);
        phase(4, 1'b0);
        phase(1, 1'b1);

        // LOAD 1 mid-high at period 8: old period completes, ACK on rising edge
        step(0, 1, 1, 4'd1, 4'b1010);
        repeat (2) step(0, 1, 0, 4'd0, 4'b1010);
        repeat (4) step(0, 1, 0, 4'd0, 4'b0010);
        step(0, 1, 0, 4'd0, 4'b1100);
        phase(1, 1'b1);
        phase(2, 1'b0);
        phase(1, 1'b1);

        // LOAD 2 then 5 in one period: single ACK, then period 12
        step(0, 1, 1, 4'd2, 4'b1010);
        step(0, 1, 1, 4'd5, 4'b0010);
        step(0, 1, 0, 4'd0, 4'b0010);
        step(0, 1, 0, 4'd0, 4'b1100);
        phase(5, 1'b1);
        phase(6, 1'b0);

        // back to period 8, with a LOAD landing on the apply edge
        step(0, 1, 1, 4'd3, 4'b1010);
        repeat (5) step(0, 1, 0, 4'd0, 4'b1010);
        repeat (6) step(0, 1, 0, 4'd0, 4'b0010);
        step(0, 1, 1, 4'd3, 4'b1110);
        repeat (3) step(0, 1, 0, 4'd0, 4'b1010);
        repeat (4) step(0, 1, 0, 4'd0, 4'b0010);
        step(0, 1, 0, 4'd0, 4'b1100);

        // EN drops in the high phase: finish high, 4 low, then stopped
        repeat (3) step(0, 0, 0, 4'd0, 4'b1000);
        repeat (4) step(0, 0, 0, 4'd0, 4'b0000);
        step(0, 0, 0, 4'd0, 4'b0001);
        step(0, 0, 0, 4'd0, 4'b0001);

        // EN re-raised during DRAIN: no gap in Y
        step(0, 1, 0, 4'd0, 4'b1000);
        step(0, 0, 0, 4'd0, 4'b1000);
        step(0, 0, 0, 4'd0, 4'b1000);
        step(0, 1, 0, 4'd0, 4'b1000);
        phase(4, 1'b0);
        phase(1, 1'b1);

        // reset with Y high and a ratio pending: pending discarded, div_act back to 0
        step(0, 1, 1, 4'd7, 4'b1010);
        step(1, 1, 0, 4'd0, 4'b0001);
        step(0, 0, 0, 4'd0, 4'b0001);
        step(0, 0, 0, 4'd0, 4'b0001);
        step(0, 1, 0, 4'd0, 4'b1000);
        step(0, 1, 0, 4'd0, 4'b0000);
        step(0, 1, 0, 4'd0, 4'b1000);
        step(0, 0, 0, 4'd0, 4'b0000);
        step(0, 0, 0, 4'd0, 4'b0001);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected outputs never compared", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
